// File: rtl/fetch_pair_buffer.sv
// Dual-issue fetch front end: doubleword fetch into a small instruction FIFO feeding two F slots.
// Optional macro FETCH_PERF_EN adds saturating full-stall and redirect counters.
module fetch_pair_buffer #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                ImemAddr,
    input  logic [31:0]                ImemRd1,
    input  logic [31:0]                ImemRd2,
    input  logic [1:0]                 take,
    output logic [31:0]                PCF1,
    output logic [31:0]                PCPlus8F1,
    output logic [31:0]                InstrF1,
    output logic                       ValidF1,
    output logic [31:0]                PCF2,
    output logic [31:0]                PCPlus8F2,
    output logic [31:0]                InstrF2,
    output logic                       ValidF2,
`ifdef FETCH_PERF_EN
    output logic [31:0]                full_stall_cnt,
    output logic [31:0]                redirect_cnt,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fpc_q, fpc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic          space_ok;
    logic          wr_en;
    logic [1:0]    push_n, pop_n, take_lim;
    logic [PW-1:0] head_nx;

    assign ImemAddr = {fpc_q[31:3], 3'b000};
    // Enqueue decision looks only at registered occupancy, never at take
    assign space_ok = (count_q <= CW'(DEPTH - 2));
    assign wr_en    = !rst && !redirect && space_ok;
    assign take_lim = (take > 2'd2) ? 2'd2 : take;
    assign head_nx  = head_q + PW'(1);

    always_comb begin
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push_n  = 2'd0;
        pop_n   = 2'd0;
        if (redirect) begin
            fpc_d   = {redirect_pc[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (space_ok) begin
                push_n = fpc_q[2] ? 2'd1 : 2'd2;
                fpc_d  = ImemAddr + 32'd8;
            end
            pop_n   = (CW'(take_lim) > count_q) ? count_q[1:0] : take_lim;
            head_d  = head_q + PW'(pop_n);
            tail_d  = tail_q + PW'(push_n);
            count_d = count_q + CW'(push_n) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage carries no reset; validity comes from count_q alone
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (fpc_q[2]) begin
                pc_mem_q[tail_q]    <= fpc_q;
                instr_mem_q[tail_q] <= ImemRd2;
            end else begin
                pc_mem_q[tail_q]             <= fpc_q;
                instr_mem_q[tail_q]          <= ImemRd1;
                pc_mem_q[tail_q + PW'(1)]    <= fpc_q + 32'd4;
                instr_mem_q[tail_q + PW'(1)] <= ImemRd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect) begin
            assert (take <= 2'd2 && CW'(take) <= count_q)
                else $warning("fetch_pair_buffer: take %0d exceeds occupancy %0d, clamped", take, count_q);
        end
    end

    assign count     = count_q;
    assign ValidF1   = (count_q >= CW'(1));
    assign ValidF2   = (count_q >= CW'(2));
    assign PCF1      = ValidF1 ? pc_mem_q[head_q]           : 32'd0;
    assign InstrF1   = ValidF1 ? instr_mem_q[head_q]        : 32'd0;
    assign PCPlus8F1 = ValidF1 ? pc_mem_q[head_q] + 32'd8   : 32'd0;
    assign PCF2      = ValidF2 ? pc_mem_q[head_nx]          : 32'd0;
    assign InstrF2   = ValidF2 ? instr_mem_q[head_nx]       : 32'd0;
    assign PCPlus8F2 = ValidF2 ? pc_mem_q[head_nx] + 32'd8  : 32'd0;

`ifdef FETCH_PERF_EN
    logic [31:0] full_stall_q, redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_stall_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (!redirect && !space_ok && full_stall_q != 32'hFFFF_FFFF)
                full_stall_q <= full_stall_q + 32'd1;
            if (redirect && redirect_cnt_q != 32'hFFFF_FFFF)
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign full_stall_cnt = full_stall_q;
    assign redirect_cnt   = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Directed table-driven bench for fetch_pair_buffer; instruction memory returns the word address as data.
module tb_fetch_pair_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ImemAddr, ImemRd1, ImemRd2;
    logic [1:0]  take;
    logic [31:0] PCF1, PCPlus8F1, InstrF1, PCF2, PCPlus8F2, InstrF2;
    logic        ValidF1, ValidF2;
    logic [3:0]  count;
`ifdef FETCH_PERF_EN
    logic [31:0] full_stall_cnt, redirect_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ImemRd1 = ImemAddr;
    assign ImemRd2 = ImemAddr + 32'd4;

    fetch_pair_buffer #(.DEPTH(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .ImemAddr(ImemAddr), .ImemRd1(ImemRd1), .ImemRd2(ImemRd2), .take(take),
        .PCF1(PCF1), .PCPlus8F1(PCPlus8F1), .InstrF1(InstrF1), .ValidF1(ValidF1),
        .PCF2(PCF2), .PCPlus8F2(PCPlus8F2), .InstrF2(InstrF2), .ValidF2(ValidF2),
`ifdef FETCH_PERF_EN
        .full_stall_cnt(full_stall_cnt), .redirect_cnt(redirect_cnt),
`endif
        .count(count)
    );

    typedef struct {
        logic [1:0]  take;
        logic        redir;
        logic [31:0] rpc;
        int          cnt;
        logic        v1;
        logic        v2;
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            take  redir rpc           cnt v1 v2 pc1           pc2           addr
        vecs[0]  = '{2'd0, 1'b0, 32'h0,          2, 1, 1, 32'h0,        32'h4,        32'h8};
        vecs[1]  = '{2'd0, 1'b0, 32'h0,          4, 1, 1, 32'h0,        32'h4,        32'h10};
        vecs[2]  = '{2'd0, 1'b0, 32'h0,          6, 1, 1, 32'h0,        32'h4,        32'h18};
        vecs[3]  = '{2'd0, 1'b0, 32'h0,          8, 1, 1, 32'h0,        32'h4,        32'h20};
        vecs[4]  = '{2'd0, 1'b0, 32'h0,          8, 1, 1, 32'h0,        32'h4,        32'h20};
        vecs[5]  = '{2'd1, 1'b0, 32'h0,          7, 1, 1, 32'h4,        32'h8,        32'h20};
        vecs[6]  = '{2'd1, 1'b0, 32'h0,          6, 1, 1, 32'h8,        32'hC,        32'h20};
        vecs[7]  = '{2'd2, 1'b0, 32'h0,          6, 1, 1, 32'h10,       32'h14,       32'h28};
        vecs[8]  = '{2'd2, 1'b0, 32'h0,          6, 1, 1, 32'h18,       32'h1C,       32'h30};
        vecs[9]  = '{2'd2, 1'b1, 32'h106,        0, 0, 0, 32'h0,        32'h0,        32'h100};
        vecs[10] = '{2'd0, 1'b0, 32'h0,          1, 1, 0, 32'h104,      32'h0,        32'h108};
        vecs[11] = '{2'd0, 1'b0, 32'h0,          3, 1, 1, 32'h104,      32'h108,      32'h110};
        vecs[12] = '{2'd1, 1'b0, 32'h0,          4, 1, 1, 32'h108,      32'h10C,      32'h118};
        vecs[13] = '{2'd0, 1'b1, 32'h1C,         0, 0, 0, 32'h0,        32'h0,        32'h18};
        vecs[14] = '{2'd0, 1'b0, 32'h0,          1, 1, 0, 32'h1C,       32'h0,        32'h20};
        vecs[15] = '{2'd2, 1'b0, 32'h0,          2, 1, 1, 32'h20,       32'h24,       32'h28};
        vecs[16] = '{2'd2, 1'b0, 32'h0,          2, 1, 1, 32'h28,       32'h2C,       32'h30};

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; take = 2'd0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset count",    32'(count),   32'd0);
        chk("reset ValidF1",  32'(ValidF1), 32'd0);
        chk("reset ValidF2",  32'(ValidF2), 32'd0);
        chk("reset PCF1",     PCF1,         32'h0);
        chk("reset InstrF1",  InstrF1,      32'h0);
        chk("reset ImemAddr", ImemAddr,     32'h0);

        for (int i = 0; i < 17; i++) begin
            take = vecs[i].take; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            step();
            take = 2'd0; redirect = 1'b0; redirect_pc = 32'h0;
            #1;
            chk($sformatf("v%0d count", i),     32'(count),   32'(vecs[i].cnt));
            chk($sformatf("v%0d ValidF1", i),   32'(ValidF1), 32'(vecs[i].v1));
            chk($sformatf("v%0d ValidF2", i),   32'(ValidF2), 32'(vecs[i].v2));
            chk($sformatf("v%0d PCF1", i),      PCF1,         vecs[i].pc1);
            chk($sformatf("v%0d InstrF1", i),   InstrF1,      vecs[i].pc1);
            chk($sformatf("v%0d PCF2", i),      PCF2,         vecs[i].pc2);
            chk($sformatf("v%0d InstrF2", i),   InstrF2,      vecs[i].pc2);
            chk($sformatf("v%0d PCPlus8F1", i), PCPlus8F1,    vecs[i].v1 ? vecs[i].pc1 + 32'd8 : 32'd0);
            chk($sformatf("v%0d PCPlus8F2", i), PCPlus8F2,    vecs[i].v2 ? vecs[i].pc2 + 32'd8 : 32'd0);
            chk($sformatf("v%0d ImemAddr", i),  ImemAddr,     vecs[i].addr);
        end

`ifdef FETCH_PERF_EN
        chk("full_stall_cnt", full_stall_cnt, 32'd3);
        chk("redirect_cnt",   redirect_cnt,   32'd2);
`endif

        // PC wrap: fetch at 0xFFFFFFF8 pushes the top pair and wraps fpc to 0
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
        step();
        redirect = 1'b0; redirect_pc = 32'h0;
        #1;
        chk("wrap redirect ImemAddr", ImemAddr, 32'hFFFF_FFF8);
        chk("wrap redirect count", 32'(count), 32'd0);
        step();
        chk("wrap count",     32'(count), 32'd2);
        chk("wrap PCF1",      PCF1,       32'hFFFF_FFF8);
        chk("wrap PCPlus8F1", PCPlus8F1,  32'h0);
        chk("wrap PCF2",      PCF2,       32'hFFFF_FFFC);
        chk("wrap PCPlus8F2", PCPlus8F2,  32'h4);
        chk("wrap ImemAddr",  ImemAddr,   32'h0);
        step();
        chk("wrap2 count",    32'(count), 32'd4);
        chk("wrap2 ImemAddr", ImemAddr,   32'h8);

        // rst wins over a simultaneous redirect
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; take = 2'd1;
        step();
        rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; take = 2'd0;
        #1;
        chk("rst+redir count",    32'(count),   32'd0);
        chk("rst+redir ValidF1",  32'(ValidF1), 32'd0);
        chk("rst+redir ImemAddr", ImemAddr,     32'h0);
        chk("rst+redir PCF1",     PCF1,         32'h0);
`ifdef FETCH_PERF_EN
        chk("rst+redir redirect_cnt",   redirect_cnt,   32'd0);
        chk("rst+redir full_stall_cnt", full_stall_cnt, 32'd0);
`endif
        step();
        chk("post-rst count", 32'(count), 32'd2);
        chk("post-rst PCF2",  PCF2,       32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
